idex_alu_decode: RTL and testbench
==================================

// Module: idex_alu_decode
// PURPOSE
//  ID/EX stage decoder and pipeline register. It produces the 4-bit aluop and operand controls that drive the EX-stage ALU.
//  Decodes one RV32I instruction per cycle, registers the controls with stall/flush/bubble handling, and flags illegal encodings.
//  aluop encoding is fixed by the ALU:
//   ADD=0000 SUB=1000 SLL=0001 SLT=0010 SLTU=0011 XOR=0100 SRL=0101 SRA=1101 OR=0110 AND=0111
// PARAMETERS
//  SUPPRESS_ILLEGAL  1  1: an illegal instr is registered with regwrite/memread/memwrite/branch/jump forced 0
//  KILL_X0_WRITE     1  1: ex_regwrite forced 0 when rd==0
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  id_valid     in   1   id_instr/id_pc hold a real instruction
//  id_instr     in   32  instruction word
//  id_pc        in   32  PC of id_instr
//  stall        in   1   hold all ex_* outputs (hazard unit)
//  flush        in   1   load a bubble (branch/jump taken)
//  ex_valid     out  1   ex_* holds a real instruction
//  ex_aluop     out  4   ALU op, encoding above
//  ex_a_sel     out  2   ALU A: 00 rs1, 01 pc, 10 zero
//  ex_b_sel     out  1   ALU B: 0 rs2, 1 ex_imm
//  ex_imm       out  32  sign-extended immediate (I/S/B/U/J)
//  ex_rs1/ex_rs2/ex_rd  out 5 each  register indices, raw from instr
//  ex_funct3    out  3   funct3, passed through for mem size / branch cond
//  ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump  out 1 each
//  ex_illegal   out  1   unsupported/illegal encoding
//  ex_pc        out  32  registered id_pc
// BEHAVIOUR
//  Reset (async, rst_n=0): every ex_* output = 0 (bubble). Outputs stay 0 until the first clk edge after release.
//  Latency: 1 cycle. Decode is combinational and is registered on the posedge.
//  Priority at each posedge: flush > stall > load.
//   flush=1 (stall ignored): bubble = ex_valid=0, all controls/aluop/imm=0.
//   stall=1 and flush=0: all ex_* hold their values.
//   Otherwise: if id_valid=1, load the decode. If id_valid=0, load a bubble.
//  R-type (0110011): aluop={instr[30],funct3}.
//   funct7 must be 0000000, or 0100000 with funct3 in {000,101}. Otherwise illegal.
//   a_sel=00, b_sel=0, regwrite=1.
//  OP-IMM (0010011): aluop={0,funct3}, except funct3=101 where aluop={instr[30],101}.
//   SLLI needs imm[11:5]=0000000. SRLI/SRAI need 0000000/0100000. Otherwise illegal.
//   Shift imm = zero-extended shamt. All other imm = sign-ext I.
//  LOAD (0000011): ADD, a=rs1, b=imm, memread=1, regwrite=1.
//   funct3 must be in {000,001,010,100,101}, else illegal.
//  STORE (0100011): ADD, a=rs1, b=imm(S), memwrite=1. funct3 must be in {000,001,010}, else illegal.
//  BRANCH (1100011): branch=1, b_sel=0, imm=B.
//   BEQ/BNE -> SUB. BLT/BGE -> SLT. BLTU/BGEU -> SLTU. funct3 010/011 -> illegal.
//  LUI: ADD, a=zero, b=imm(U), regwrite=1. AUIPC: ADD, a=pc, b=imm(U), regwrite=1.
//  JAL: jump=1, regwrite=1, ADD, a=pc, b=imm(J).
//  JALR: jump=1, regwrite=1, ADD, a=rs1, b=imm(I). funct3 must be 000, else illegal.
//  Any other opcode, or instr[1:0]!=11: illegal=1, aluop=ADD, all side-effect controls 0.
//  Illegal: ex_valid stays 1 so the trap logic sees it. Side effects are gated per SUPPRESS_ILLEGAL.
//  KILL_X0_WRITE applies after decode. ex_rd itself is still registered unchanged.
//  rst_n asserted mid-stall or mid-flush: outputs go to 0 immediately. The held instruction is lost.
// TESTING
//  1. add x3,x1,x2 0x002081B3, id_valid=1
//     -> next cycle ex_valid=1, aluop=0000, a_sel=00, b_sel=0, rd=3, rs1=1, rs2=2, regwrite=1
//  2. sub 0x402081B3 -> aluop=1000
//     srai x5,x6,3 0x40335293 -> aluop=1101, b_sel=1, imm=0x00000003
//  3. lw x4,-4(x2) 0xFFC12203 -> aluop=0000, imm=0xFFFFFFFC, memread=1, regwrite=1, funct3=010
//  4. Load add, then hold stall=1 for 3 cycles while id_instr changes -> ex_* unchanged.
//     Then flush=1 together with stall=1 -> ex_valid=0, regwrite=0 next cycle.
//  5. 0xFE0081B3 (funct7=1111111) -> ex_illegal=1, ex_valid=1, regwrite=0.
//     addi x0,x0,1 0x00100013 -> regwrite=0.
//  6. Drop rst_n mid-cycle with ex_valid=1 -> all ex_* = 0 before the next clk edge.
//     Release rst_n -> outputs stay 0 until the first loaded instruction.

Source files
------------

// File: rtl/idex_alu_decode.sv
// ID/EX stage: combinational RV32I decode of the ID instruction feeding a pipeline register
// with flush > stall > load priority; produces ALU op, operand selects, immediate and control flags.
module idex_alu_decode #(
    parameter bit SUPPRESS_ILLEGAL = 1'b1,
    parameter bit KILL_X0_WRITE    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [3:0]  ex_aluop,
    output logic [1:0]  ex_a_sel,
    output logic        ex_b_sel,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_illegal,
    output logic [31:0] ex_pc
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_ZERO = 2'b10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [31:0] pc;
    } ex_t;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_sh_s;
    logic        suppress_s;
    logic        kill_x0_s;
    ex_t         dec_s;
    ex_t         gated_s;
    ex_t         ex_r;

    assign opcode_s = id_instr[6:0];
    assign funct3_s = id_instr[14:12];
    assign funct7_s = id_instr[31:25];

    assign imm_i_s  = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s_s  = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b_s  = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_u_s  = {id_instr[31:12], 12'h000};
    assign imm_j_s  = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};
    assign imm_sh_s = {27'd0, id_instr[24:20]};

    // Raw instruction decode: opcode/funct fields to ALU controls and legality
    always_comb begin
        dec_s        = '0;
        dec_s.valid  = 1'b1;
        dec_s.aluop  = ALU_ADD;
        dec_s.rs1    = id_instr[19:15];
        dec_s.rs2    = id_instr[24:20];
        dec_s.rd     = id_instr[11:7];
        dec_s.funct3 = funct3_s;
        dec_s.pc     = id_pc;
        case (opcode_s)
            OP_R: begin
                dec_s.aluop    = {id_instr[30], funct3_s};
                dec_s.regwrite = 1'b1;
                if (funct7_s == F7_ZERO) begin
                    dec_s.illegal = 1'b0;
                end else if ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    dec_s.illegal = 1'b0;
                end else begin
                    dec_s.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec_s.b_sel    = 1'b1;
                dec_s.regwrite = 1'b1;
                case (funct3_s)
                    3'b001: begin
                        dec_s.aluop   = {1'b0, funct3_s};
                        dec_s.imm     = imm_sh_s;
                        dec_s.illegal = (funct7_s != F7_ZERO);
                    end
                    3'b101: begin
                        dec_s.aluop   = {id_instr[30], 3'b101};
                        dec_s.imm     = imm_sh_s;
                        dec_s.illegal = (funct7_s != F7_ZERO) && (funct7_s != F7_ALT);
                    end
                    default: begin
                        dec_s.aluop = {1'b0, funct3_s};
                        dec_s.imm   = imm_i_s;
                    end
                endcase
            end
            OP_LOAD: begin
                dec_s.b_sel    = 1'b1;
                dec_s.imm      = imm_i_s;
                dec_s.memread  = 1'b1;
                dec_s.regwrite = 1'b1;
                case (funct3_s)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_s.illegal = 1'b0;
                    default:                                dec_s.illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                dec_s.b_sel    = 1'b1;
                dec_s.imm      = imm_s_s;
                dec_s.memwrite = 1'b1;
                case (funct3_s)
                    3'b000, 3'b001, 3'b010: dec_s.illegal = 1'b0;
                    default:                dec_s.illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                dec_s.branch = 1'b1;
                dec_s.imm    = imm_b_s;
                case (funct3_s)
                    3'b000, 3'b001: dec_s.aluop = ALU_SUB;
                    3'b100, 3'b101: dec_s.aluop = ALU_SLT;
                    3'b110, 3'b111: dec_s.aluop = ALU_SLTU;
                    default:        dec_s.illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec_s.a_sel    = A_ZERO;
                dec_s.b_sel    = 1'b1;
                dec_s.imm      = imm_u_s;
                dec_s.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                dec_s.a_sel    = A_PC;
                dec_s.b_sel    = 1'b1;
                dec_s.imm      = imm_u_s;
                dec_s.regwrite = 1'b1;
            end
            OP_JAL: begin
                dec_s.a_sel    = A_PC;
                dec_s.b_sel    = 1'b1;
                dec_s.imm      = imm_j_s;
                dec_s.jump     = 1'b1;
                dec_s.regwrite = 1'b1;
            end
            OP_JALR: begin
                dec_s.a_sel    = A_RS1;
                dec_s.b_sel    = 1'b1;
                dec_s.imm      = imm_i_s;
                dec_s.jump     = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.illegal  = (funct3_s != 3'b000);
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
    end

    // Side-effect gating for illegal encodings and writes to x0
    always_comb begin
        suppress_s       = SUPPRESS_ILLEGAL && dec_s.illegal;
        kill_x0_s        = KILL_X0_WRITE && (dec_s.rd == 5'd0);
        gated_s          = dec_s;
        gated_s.regwrite = dec_s.regwrite & ~suppress_s & ~kill_x0_s;
        gated_s.memread  = dec_s.memread  & ~suppress_s;
        gated_s.memwrite = dec_s.memwrite & ~suppress_s;
        gated_s.branch   = dec_s.branch   & ~suppress_s;
        gated_s.jump     = dec_s.jump     & ~suppress_s;
    end

    // ID/EX pipeline register: flush beats stall beats load; no valid input loads a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r <= '0;
        end else if (flush) begin
            ex_r <= '0;
        end else if (stall) begin
            ex_r <= ex_r;
        end else if (id_valid) begin
            ex_r <= gated_s;
        end else begin
            ex_r <= '0;
        end
    end

    assign ex_valid    = ex_r.valid;
    assign ex_aluop    = ex_r.aluop;
    assign ex_a_sel    = ex_r.a_sel;
    assign ex_b_sel    = ex_r.b_sel;
    assign ex_imm      = ex_r.imm;
    assign ex_rs1      = ex_r.rs1;
    assign ex_rs2      = ex_r.rs2;
    assign ex_rd       = ex_r.rd;
    assign ex_funct3   = ex_r.funct3;
    assign ex_regwrite = ex_r.regwrite;
    assign ex_memread  = ex_r.memread;
    assign ex_memwrite = ex_r.memwrite;
    assign ex_branch   = ex_r.branch;
    assign ex_jump     = ex_r.jump;
    assign ex_illegal  = ex_r.illegal;
    assign ex_pc       = ex_r.pc;

endmodule

// File: tb/tb_idex_alu_decode.sv
// Self-checking bench for idex_alu_decode: directed cases plus randomized stream
// checked against an instruction-level reference model.
module tb_idex_alu_decode;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_aluop;
    logic [1:0]  ex_a_sel;
    logic        ex_b_sel;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_illegal;
    logic [31:0] ex_pc;

    int checks;
    int failures;

    logic [95:0] obs_s;
    logic [95:0] exp_r;

    idex_alu_decode dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
        .ex_a_sel(ex_a_sel), .ex_b_sel(ex_b_sel), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
    );

    assign obs_s = {ex_valid, ex_aluop, ex_a_sel, ex_b_sel, ex_imm, ex_rs1, ex_rs2, ex_rd,
                    ex_funct3, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump,
                    ex_illegal, ex_pc};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what the EX stage should hold for one instruction, from the ISA rules
    function automatic logic [95:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        logic signed [31:0] s;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic        b;
        logic [31:0] im;
        logic        rw, mr, mw, br, jp, ill;
        s = ins; f3 = ins[14:12]; f7 = ins[31:25];
        alu = 4'b0000; a = 2'b00; b = 1'b0; im = 32'd0;
        rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0; ill = 1'b0;
        case (ins[6:0])
            7'h33: begin
                alu = {ins[30], f3}; rw = 1'b1;
                ill = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                b = 1'b1; rw = 1'b1;
                if (f3 == 3'd1) begin
                    alu = 4'b0001; im = 32'(ins[24:20]); ill = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    alu = ins[30] ? 4'b1101 : 4'b0101; im = 32'(ins[24:20]);
                    ill = !((f7 == 7'h00) || (f7 == 7'h20));
                end else begin
                    alu = {1'b0, f3}; im = 32'(s >>> 20);
                end
            end
            7'h03: begin
                b = 1'b1; mr = 1'b1; rw = 1'b1; im = 32'(s >>> 20);
                ill = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
            end
            7'h23: begin
                b = 1'b1; mw = 1'b1;
                im = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
                ill = (f3 > 3'd2);
            end
            7'h63: begin
                br = 1'b1;
                im = (32'(s >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
                if (f3 <= 3'd1) alu = 4'b1000;
                else if (f3 == 3'd4 || f3 == 3'd5) alu = 4'b0010;
                else if (f3 >= 3'd6) alu = 4'b0011;
                else ill = 1'b1;
            end
            7'h37: begin a = 2'b10; b = 1'b1; rw = 1'b1; im = ins & 32'hFFFFF000; end
            7'h17: begin a = 2'b01; b = 1'b1; rw = 1'b1; im = ins & 32'hFFFFF000; end
            7'h6F: begin
                a = 2'b01; b = 1'b1; rw = 1'b1; jp = 1'b1;
                im = (32'(s >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67: begin
                b = 1'b1; rw = 1'b1; jp = 1'b1; im = 32'(s >>> 20); ill = (f3 != 3'd0);
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0; end
        if (ins[11:7] == 5'd0) rw = 1'b0;
        return {1'b1, alu, a, b, im, ins[19:15], ins[24:20], ins[11:7], f3,
                rw, mr, mw, br, jp, ill, pc};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        logic [6:0]  ops [9];
        int          sel;
        int          f7c;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        ins = $urandom;
        sel = $urandom_range(0, 10);
        if (sel < 9) ins[6:0] = ops[sel];
        f7c = $urandom_range(0, 3);
        if (f7c <= 1) ins[31:25] = 7'h00;
        else if (f7c == 2) ins[31:25] = 7'h20;
        return ins;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        id_valid = v; id_instr = ins; id_pc = pc; stall = st; flush = fl;
    endtask

    // Advance one clock, updating the expected register contents first
    task automatic tick();
        logic [95:0] nxt;
        if (!rst_n) nxt = 96'd0;
        else if (flush) nxt = 96'd0;
        else if (stall) nxt = exp_r;
        else if (id_valid) nxt = ref_decode(id_instr, id_pc);
        else nxt = 96'd0;
        @(posedge clk);
        #1;
        exp_r = nxt;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs_s !== 96'd0) begin
            failures++; $display("FAIL reset_state obs=%h exp=0", obs_s);
        end
        drive(1'b1, 32'h002081B3, 32'h0000_0040, 1'b0, 1'b0);
        repeat (2) tick();
        checks++;
        if (obs_s !== 96'd0) begin
            failures++; $display("FAIL reset_held obs=%h exp=0", obs_s);
        end
        drive(1'b0, 32'h002081B3, 32'h0000_0040, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_s !== 96'd0) begin
            failures++; $display("FAIL reset_release_bubble obs=%h exp=0", obs_s);
        end
    endtask

    task automatic test_alu_ops();
        drive(1'b1, 32'h002081B3, 32'h0000_1000, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_valid, ex_aluop, ex_a_sel, ex_b_sel, ex_rd, ex_rs1, ex_rs2, ex_regwrite} !==
            {1'b1, 4'b0000, 2'b00, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1}) begin
            failures++; $display("FAIL add_fields obs=%h", obs_s);
        end
        checks++;
        if (obs_s !== exp_r) begin failures++; $display("FAIL add_model obs=%h exp=%h", obs_s, exp_r); end

        drive(1'b1, 32'h402081B3, 32'h0000_1004, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_valid, ex_aluop, ex_regwrite} !== {1'b1, 4'b1000, 1'b1}) begin
            failures++; $display("FAIL sub_aluop obs=%h exp=1000", ex_aluop);
        end

        drive(1'b1, 32'h40335293, 32'h0000_1008, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_aluop, ex_b_sel, ex_imm, ex_rd, ex_rs1, ex_illegal} !==
            {4'b1101, 1'b1, 32'h00000003, 5'd5, 5'd6, 1'b0}) begin
            failures++; $display("FAIL srai_fields obs=%h", obs_s);
        end

        drive(1'b1, 32'hFFC12203, 32'h0000_100C, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_aluop, ex_imm, ex_memread, ex_regwrite, ex_funct3, ex_rd, ex_pc} !==
            {4'b0000, 32'hFFFFFFFC, 1'b1, 1'b1, 3'b010, 5'd4, 32'h0000_100C}) begin
            failures++; $display("FAIL lw_fields obs=%h", obs_s);
        end
        checks++;
        if (obs_s !== exp_r) begin failures++; $display("FAIL lw_model obs=%h exp=%h", obs_s, exp_r); end
    endtask

    task automatic test_stall_flush();
        logic [95:0] held;
        drive(1'b1, 32'h002081B3, 32'h0000_2000, 1'b0, 1'b0);
        tick();
        held = obs_s;
        checks++;
        if (ex_valid !== 1'b1) begin failures++; $display("FAIL stall_preload valid=%b exp=1", ex_valid); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, gen_instr(), $urandom, 1'b1, 1'b0);
            tick();
            checks++;
            if (obs_s !== held) begin
                failures++; $display("FAIL stall_hold%0d obs=%h exp=%h", i, obs_s, held);
            end
        end
        drive(1'b1, 32'h402081B3, 32'h0000_2010, 1'b1, 1'b1);
        tick();
        checks++;
        if ({ex_valid, ex_regwrite} !== 2'b00 || obs_s !== 96'd0) begin
            failures++; $display("FAIL flush_over_stall obs=%h exp=0", obs_s);
        end
        drive(1'b0, 32'h002081B3, 32'h0000_2014, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_s !== 96'd0) begin failures++; $display("FAIL idle_bubble obs=%h exp=0", obs_s); end
    endtask

    task automatic test_illegal();
        logic [31:0] cases [4];
        cases = '{32'hFE0081B3, 32'h00000001, 32'h00002063, 32'h0000107F};
        drive(1'b1, 32'hFE0081B3, 32'h0000_3000, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_illegal, ex_valid, ex_regwrite} !== 3'b110) begin
            failures++; $display("FAIL bad_funct7 ill/valid/rw=%b%b%b exp=110", ex_illegal, ex_valid, ex_regwrite);
        end
        drive(1'b1, 32'h00100013, 32'h0000_3004, 1'b0, 1'b0);
        tick();
        checks++;
        if ({ex_valid, ex_regwrite, ex_illegal, ex_imm, ex_b_sel} !== {1'b1, 1'b0, 1'b0, 32'd1, 1'b1}) begin
            failures++; $display("FAIL addi_x0 obs=%h", obs_s);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, cases[i], 32'h0000_3100 + 32'(i * 4), 1'b0, 1'b0);
            tick();
            checks++;
            if (obs_s !== exp_r || ex_illegal !== 1'b1) begin
                failures++; $display("FAIL illegal_case%0d obs=%h exp=%h", i, obs_s, exp_r);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h002081B3, 32'h0000_4000, 1'b0, 1'b0);
        tick();
        checks++;
        if (ex_valid !== 1'b1) begin failures++; $display("FAIL areset_preload valid=%b exp=1", ex_valid); end
        drive(1'b1, 32'h002081B3, 32'h0000_4004, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_r = 96'd0;
        #1;
        checks++;
        if (obs_s !== 96'd0) begin failures++; $display("FAIL areset_immediate obs=%h exp=0", obs_s); end
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_s !== 96'd0) begin failures++; $display("FAIL areset_stall_after obs=%h exp=0", obs_s); end
        drive(1'b0, 32'h002081B3, 32'h0000_4008, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_s !== 96'd0) begin failures++; $display("FAIL areset_idle obs=%h exp=0", obs_s); end
        drive(1'b1, 32'h002081B3, 32'h0000_400C, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_s !== exp_r || ex_valid !== 1'b1) begin
            failures++; $display("FAIL areset_first_load obs=%h exp=%h", obs_s, exp_r);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) < 85, gen_instr(), $urandom,
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
            tick();
            checks++;
            if (obs_s !== exp_r) begin
                failures++; $display("FAIL random%0d instr=%h obs=%h exp=%h", i, id_instr, obs_s, exp_r);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_r = 96'd0;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_alu_ops();
        test_stall_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
